// File: rtl/imm_ext_pipe.sv
// Sign/zero extender for run-time-width immediate fields, buffered by a 2-entry valid/ready FIFO.
// Optional left shift of the extended value is enabled by defining SHIFT_EN.
module imm_ext_pipe #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(IN_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_signed,
    input  logic [1:0]       in_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             occ_q, occ_d;
    logic [OUT_W-1:0] head_data_q, head_data_d;
    logic             head_err_q, head_err_d;
    logic [OUT_W-1:0] tail_data_q, tail_data_d;
    logic             tail_err_q, tail_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             legal;
    logic             sign_bit;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] new_data;
    logic             new_err;
    logic             push, pop;

    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != EMPTY);
    assign out_data  = head_data_q;
    assign out_err   = head_err_q;
    assign err_cnt   = err_cnt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifndef SHIFT_EN
    logic [1:0] unused_shift;
    assign unused_shift = in_shift;
`endif

    always_comb begin
        legal    = (in_len != '0) && (in_len <= LEN_W'(IN_W));
        sign_bit = 1'b0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (LEN_W'(i + 1) == in_len) sign_bit = in_data[i];
        end
        // Fill every bit with the extension bit, then overlay the live field bits.
        ext = '0;
        for (int unsigned i = 0; i < OUT_W; i++) ext[i] = in_signed & sign_bit;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (LEN_W'(i) < in_len) ext[i] = in_data[i];
        end
`ifdef SHIFT_EN
        ext = ext << in_shift;
`endif
        new_data = legal ? ext : '0;
        new_err  = ~legal;
    end

    always_comb begin
        occ_d       = occ_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;
        err_cnt_d   = err_cnt_q;

        unique case (occ_q)
            EMPTY: begin
                if (push) begin
                    head_data_d = new_data;
                    head_err_d  = new_err;
                    occ_d       = ONE;
                end
            end
            ONE: begin
                if (push) begin
                    if (pop) begin
                        head_data_d = new_data;
                        head_err_d  = new_err;
                    end else begin
                        tail_data_d = new_data;
                        tail_err_d  = new_err;
                        occ_d       = FULL;
                    end
                end else if (pop) begin
                    head_data_d = '0;
                    head_err_d  = 1'b0;
                    occ_d       = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                    tail_data_d = '0;
                    tail_err_d  = 1'b0;
                    occ_d       = ONE;
                end
            end
            default: begin
                occ_d       = EMPTY;
                head_data_d = '0;
                head_err_d  = 1'b0;
            end
        endcase

        if (push && !legal && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= EMPTY;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            occ_q       <= occ_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_err_q  <= tail_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule
